// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared FSM/operand-class types and IEEE-style encodings for fp_mult_seq
package fp_mult_pkg;
  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_e;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} op_class_e;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic logic [63:0] inf_enc(input logic s, input int ew, input int mw);
    return (64'(s) << (ew + mw)) | (((64'd1 << ew) - 64'd1) << mw);
  endfunction
  function automatic logic [63:0] zero_enc(input logic s, input int ew, input int mw);
    return 64'(s) << (ew + mw);
  endfunction
  function automatic logic [63:0] nan_enc(input int ew, input int mw);
    return inf_enc(1'b0, ew, mw) | (64'd1 << (mw - 1));
  endfunction
endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise raw significand product, round-to-nearest-even, detect overflow/underflow
module fp_norm_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W,
  localparam int SW = MAN_W + 1,
  localparam int PW = 2 * SW,
  localparam int EW2 = EXP_W + 2
) (
  input  logic [PW-1:0]         i_prod,
  input  logic signed [EW2-1:0] i_exp,
  input  logic                  i_sign,
  output logic [W-1:0]          o_result,
  output logic                  o_ovf,
  output logic                  o_unf
);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EZERO = '0;
  logic                  w_hi, w_g, w_r, w_s, w_up, w_carry;
  logic [PW-2:0]         w_p;
  logic [MAN_W:0]        w_fsum;
  logic signed [EW2-1:0] w_e;
  // w_p drops the hidden bit: fraction sits at [PW-2:SW], guard/round/sticky below it
  always_comb begin
    w_hi = i_prod[PW-1];
    w_p = w_hi ? i_prod[PW-2:0] : {i_prod[PW-3:0], 1'b0};
    w_g = w_p[SW-1];
    w_r = w_p[SW-2];
    w_s = |w_p[SW-3:0];
    w_up = w_g && (w_r || w_s || w_p[SW]);
    w_fsum = {1'b0, w_p[PW-2:SW]} + (MAN_W+1)'(w_up);
    w_carry = w_fsum[MAN_W];
    w_e = i_exp + $signed(EW2'(w_hi)) + $signed(EW2'(w_carry));
    o_ovf = w_e >= EMAX;
    o_unf = w_e <= EZERO;
    o_result = o_ovf ? W'(inf_enc(i_sign, EXP_W, MAN_W))
             : o_unf ? W'(zero_enc(i_sign, EXP_W, MAN_W))
             : {i_sign, w_e[EXP_W-1:0], w_fsum[MAN_W-1:0]};
  end
endmodule

// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential shift-add floating-point multiplier with valid/ready handshake
module fp_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dataA,
  input  logic [W-1:0] dataB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dataR,
  output logic         flag_ovf,
  output logic         flag_unf,
  output logic         flag_inv
);
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW2 = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 1);
  localparam logic [W-1:0] NAN_R = W'(nan_enc(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(bias(EXP_W));
  localparam logic [CW-1:0] CNT_LAST = CW'(MAN_W);
  state_e                r_state, w_next;
  op_class_e             w_ca, w_cb;
  logic [PW-1:0]         r_acc, r_mcand;
  logic [SW-1:0]         r_mplier;
  logic [CW-1:0]         r_cnt;
  logic signed [EW2-1:0] r_exp;
  logic                  r_sign, r_ovf, r_unf, r_inv;
  logic [W-1:0]          r_res, w_spec_res, w_nr_res;
  logic                  w_sign, w_nan, w_inf, w_special, w_nr_ovf, w_nr_unf;
  logic [EXP_W-1:0]      w_ea, w_eb;
  logic [MAN_W-1:0]      w_fa, w_fb;
  function automatic op_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    return e == '0 ? ZERO : !(&e) ? NORMAL : f == '0 ? INF : NAN;
  endfunction
  always_comb begin
    w_ea = dataA[W-2 -: EXP_W];
    w_eb = dataB[W-2 -: EXP_W];
    w_fa = dataA[MAN_W-1:0];
    w_fb = dataB[MAN_W-1:0];
    w_ca = classify(w_ea, w_fa);
    w_cb = classify(w_eb, w_fb);
    w_sign = dataA[W-1] ^ dataB[W-1];
    w_nan = w_ca == NAN || w_cb == NAN || (w_ca == INF && w_cb == ZERO) || (w_ca == ZERO && w_cb == INF);
    w_inf = w_ca == INF || w_cb == INF;
    w_special = w_ca != NORMAL || w_cb != NORMAL;
    w_spec_res = w_nan ? NAN_R
               : w_inf ? W'(inf_enc(w_sign, EXP_W, MAN_W))
               : W'(zero_enc(w_sign, EXP_W, MAN_W));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? (w_special ? DONE : MULT) : IDLE;
      MULT:    w_next = r_cnt == CNT_LAST ? NORM : MULT;
      NORM:    w_next = DONE;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    dataR = r_res;
    flag_ovf = r_ovf;
    flag_unf = r_unf;
    flag_inv = r_inv;
  end
  // One multiplier bit per MULT cycle, LSB first, multiplicand shifting up alongside
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_cnt <= '0;
      r_exp <= '0;
      r_sign <= 1'b0;
      r_res <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_inv <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_acc <= '0;
          r_cnt <= '0;
          r_mcand <= PW'({1'b1, w_fa});
          r_mplier <= {1'b1, w_fb};
          r_exp <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S;
          r_sign <= w_sign;
          if (w_special) begin
            r_res <= w_spec_res;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_inv <= w_nan;
          end
        end
        MULT: begin
          r_acc <= r_mplier[0] ? r_acc + r_mcand : r_acc;
          r_mcand <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt <= r_cnt + 1'b1;
        end
        NORM: begin
          r_res <= w_nr_res;
          r_ovf <= w_nr_ovf;
          r_unf <= w_nr_unf;
          r_inv <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
    .i_prod  (r_acc),
    .i_exp   (r_exp),
    .i_sign  (r_sign),
    .o_result(w_nr_res),
    .o_ovf   (w_nr_ovf),
    .o_unf   (w_nr_unf)
  );
endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: directed single-precision vectors with hand-computed products, latency and handshake checks
module tb_fp_mult_seq;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, flag_ovf, flag_unf, flag_inv;
  logic [31:0] dataA = '0, dataB = '0, dataR;
  int          n_tests = 0, n_fail = 0;
  fp_mult_seq dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dataA    (dataA),
    .dataB    (dataB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dataR    (dataR),
    .flag_ovf (flag_ovf),
    .flag_unf (flag_unf),
    .flag_inv (flag_inv)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [2:0] fl, input int lat_exp);
    int lat;
    @(negedge clk);
    dataA = a;
    dataB = b;
    in_valid = 1'b1;
    check({tag, "_rdy"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    dataA = ~a;
    dataB = ~b;
    wait_done(lat);
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_res"}, dataR, r);
    check({tag, "_flg"}, 32'({flag_ovf, flag_unf, flag_inv}), 32'(fl));
    @(negedge clk);
    check({tag, "_drop"}, 32'(out_valid), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(in_ready), 1);
    check("rst_vld", 32'(out_valid), 0);
    check("rst_res", dataR, 0);
    check("rst_flg", 32'({flag_ovf, flag_unf, flag_inv}), 0);
    run_op("mul3x2",  32'h40400000, 32'h40000000, 32'h40C00000, 3'b000, 26);
    run_op("rnd_lsb", 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 26);
    run_op("norm",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26);
    run_op("rnd_up",  32'h3FC00001, 32'h3FC00000, 32'h40100001, 3'b000, 26);
    run_op("trunc",   32'h3F800001, 32'h3FFFFFFF, 32'h40000000, 3'b000, 26);
    run_op("neg",     32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 26);
    run_op("ovf",     32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 26);
    run_op("inv",     32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1);
    run_op("unf",     32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 26);
    run_op("nan_in",  32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b001, 1);
    run_op("inf",     32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1);
    run_op("zero",    32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1);
    out_ready = 1'b0;
    @(negedge clk);
    dataA = 32'h40400000;
    dataB = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    check("bp_lat", lat, 26);
    dataA = 32'h3FC00000;
    dataB = 32'h3FC00000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_res", dataR, 32'h40C00000);
      check("bp_flg", 32'({flag_ovf, flag_unf, flag_inv}), 0);
      check("bp_vld", 32'(out_valid), 1);
      check("bp_rdy", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_rdy", 32'(in_ready), 1);
    check("bp_rel_vld", 32'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp2_acc", 32'(in_ready), 0);
    wait_done(lat);
    check("bp2_lat", lat, 26);
    check("bp2_res", dataR, 32'h40100000);
    @(negedge clk);
    dataA = 32'h40400000;
    dataB = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_rdy", 32'(in_ready), 1);
    check("mrst_vld", 32'(out_valid), 0);
    check("mrst_res", dataR, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mrst_quiet", seen, 0);
    run_op("post_rst", 32'h40400000, 32'h40000000, 32'h40C00000, 3'b000, 26);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
